mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MIPS pipeline MEM stage, directly downstream of EX_Stage; consumes its registered EX/MEM outputs.
- Owns the data memory: byte/half/word loads and stores, little-endian.
- Resolves the branch decision from the Zero flag.
- Registers the MEM/WB pipeline register that feeds write-back.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit words in data memory (power of two).
- ADDR_BITS, 10, log2(MEM_DEPTH); word index = address[ADDR_BITS+1:2].

Ports:
- clk  in  1  pipeline clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_RegWrite  in  1  write-back enable from EX.
- in_MemWrite  in  1  store enable.
- in_MemRead  in  1  load enable.
- in_MemToReg  in  1  write-back source select (1 = memory data).
- in_Branch  in  1  instruction is a beq-type branch.
- in_load_mode  in  2  access size: 0 word, 1 half signed, 2 byte signed, 3 byte unsigned.
- in_zero  in  1  ALU zero flag.
- in_writebackDestination  in  5  destination register.
- in_aluResult  in  32  effective address / ALU result.
- in_rt  in  32  store data.
- in_pc  in  32  branch target from EX.
- pc_src_out  out  1  take branch (combinational).
- branch_target_out  out  32  in_pc passthrough (combinational).
- RegWrite_out  out  1  registered.
- MemToReg_out  out  1  registered.
- writebackDestination_out  out  5  registered.
- aluResult_out  out  32  registered.
- memData_out  out  32  registered, extended load data.
- misaligned_out  out  1  registered alignment-fault flag.

Behaviour:
- Reset (rst_n low, async): all registered outputs go to 0 immediately. Data memory is not cleared.
- Branch resolution: pc_src_out = in_Branch & in_zero, combinational, no latency. branch_target_out = in_pc.
- Address: word index = in_aluResult[ADDR_BITS+1:2]. Upper address bits are ignored, so addresses wrap modulo MEM_DEPTH*4.
- Alignment:
  - Mode 0 requires addr[1:0]=0.
  - Mode 1 requires addr[0]=0.
  - Modes 2/3 are always aligned.
  - misaligned = (in_MemRead | in_MemWrite) & not aligned.
- Store (posedge clk, in_MemWrite=1, aligned, rst_n high):
  - Mode 0 writes all 4 bytes.
  - Mode 1 writes in_rt[15:0] to byte lanes {addr[1],0} and {addr[1],1}.
  - Modes 2/3 write in_rt[7:0] to lane addr[1:0].
  - Unselected lanes are unchanged.
- Misaligned store: the write is suppressed entirely.
- Load data: the memory word is read asynchronously at the index.
  - Mode 0: whole word.
  - Mode 1: halfword selected by addr[1], sign-extended.
  - Mode 2: byte selected by addr[1:0], sign-extended.
  - Mode 3: byte selected by addr[1:0], zero-extended.
- MEM/WB register, updated every posedge:
  - aluResult_out, writebackDestination_out and MemToReg_out ← their inputs.
  - memData_out ← extended load data if in_MemRead, else 0.
  - misaligned_out ← misaligned.
  - RegWrite_out ← in_RegWrite & ~misaligned.
- Latency: 1 cycle from inputs to registered outputs.
- in_MemRead and in_MemWrite both 1 on the same edge: read-before-write. memData_out captures the pre-store contents; the store takes effect for later reads.
- Back-to-back store then load to the same address on consecutive cycles: the load sees the new data.
- Reset asserted mid-operation: any store on that edge is not performed, and outputs go to 0.

Test Plan:
- Reset: assert rst_n=0 between edges → all registered outputs 0 immediately, before the next edge.
- Word store/load:
  - MemWrite=1, mode 0, addr 32, rt=0xDEADBEEF.
  - Next cycle MemRead=1, mode 0, addr 32 → memData_out=0xDEADBEEF one edge later.
- Sub-word loads on word 0x8899AABB at addr 8:
  - Mode 2 at addr 9 → 0xFFFFFFAA.
  - Mode 3 at addr 9 → 0x000000AA.
  - Mode 1 at addr 10 → 0xFFFF8899.
- Byte store lane isolation: mode 2 store of rt=0x11 at addr 11 over 0x8899AABB → word reads back 0x1199AABB.
- Misaligned access:
  - Mode 0 store at addr 34 → memory unchanged, misaligned_out=1, RegWrite_out=0 even with in_RegWrite=1.
  - Mode 1 load at addr 33 → misaligned_out=1.
- Simultaneous read/write and branch:
  - MemRead=MemWrite=1, mode 0, addr 7*4, old word 7, rt=8 → memData_out=7, subsequent read gives 8.
  - in_Branch=1, in_zero=1 → pc_src_out=1 in the same cycle.
  - in_zero=0 → pc_src_out=0.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage: MIPS MEM stage with little-endian byte-addressed data memory,
// branch resolution and the MEM/WB pipeline register.   Rev 1.0
// ============================================================================
module mem_stage #(
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_RegWrite,
    input  logic        in_MemWrite,
    input  logic        in_MemRead,
    input  logic        in_MemToReg,
    input  logic        in_Branch,
    input  logic [1:0]  in_load_mode,
    input  logic        in_zero,
    input  logic [4:0]  in_writebackDestination,
    input  logic [31:0] in_aluResult,
    input  logic [31:0] in_rt,
    input  logic [31:0] in_pc,
    output logic        pc_src_out,
    output logic [31:0] branch_target_out,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic [4:0]  writebackDestination_out,
    output logic [31:0] aluResult_out,
    output logic [31:0] memData_out,
    output logic        misaligned_out
);

    localparam logic [1:0] c_MODE_WORD  = 2'd0;
    localparam logic [1:0] c_MODE_HALF  = 2'd1;
    localparam logic [1:0] c_MODE_BYTES = 2'd2;

    logic [31:0]          mem_q [0:MEM_DEPTH-1];
    logic [ADDR_BITS-1:0] w_idx;
    logic [1:0]           w_off;
    logic                 w_aligned;
    logic                 w_misaligned;
    logic [3:0]           w_be;
    logic [31:0]          w_wdata;
    logic [31:0]          w_word;
    logic [15:0]          w_half;
    logic [7:0]           w_byte;
    logic [31:0]          w_load;

    logic                 regwrite_q, memtoreg_q, misaligned_q;
    logic [4:0]           wbdest_q;
    logic [31:0]          alu_q, memdata_q;
    logic                 regwrite_d, misaligned_d;
    logic [31:0]          memdata_d;

    assign pc_src_out        = in_Branch & in_zero;
    assign branch_target_out = in_pc;

    assign w_idx  = in_aluResult[ADDR_BITS+1:2];
    assign w_off  = in_aluResult[1:0];
    assign w_word = mem_q[w_idx];
    assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];
    assign w_byte = w_word[8*w_off +: 8];

    always_comb begin
        w_aligned = 1'b1;
        w_be      = 4'b0000;
        w_wdata   = in_rt;
        w_load    = w_word;
        case (in_load_mode)
            c_MODE_WORD: begin
                w_aligned = (w_off == 2'b00);
                w_be      = 4'b1111;
                w_load    = w_word;
            end
            c_MODE_HALF: begin
                w_aligned = ~w_off[0];
                w_be      = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{in_rt[15:0]}};
                w_load    = {{16{w_half[15]}}, w_half};
            end
            c_MODE_BYTES: begin
                w_be      = 4'b0001 << w_off;
                w_wdata   = {4{in_rt[7:0]}};
                w_load    = {{24{w_byte[7]}}, w_byte};
            end
            default: begin
                w_be      = 4'b0001 << w_off;
                w_wdata   = {4{in_rt[7:0]}};
                w_load    = {24'd0, w_byte};
            end
        endcase
    end

    assign w_misaligned = (in_MemRead | in_MemWrite) & ~w_aligned;
    assign misaligned_d = w_misaligned;
    assign regwrite_d   = in_RegWrite & ~w_misaligned;
    assign memdata_d    = in_MemRead ? w_load : 32'd0;

    // Memory is never cleared; reset only blocks a store landing on its edge.
    always_ff @(posedge clk) begin
        if (rst_n && in_MemWrite && w_aligned) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    mem_q[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            misaligned_q <= 1'b0;
            wbdest_q     <= 5'd0;
            alu_q        <= 32'd0;
            memdata_q    <= 32'd0;
        end else begin
            regwrite_q   <= regwrite_d;
            memtoreg_q   <= in_MemToReg;
            misaligned_q <= misaligned_d;
            wbdest_q     <= in_writebackDestination;
            alu_q        <= in_aluResult;
            memdata_q    <= memdata_d;
        end
    end

    assign RegWrite_out             = regwrite_q;
    assign MemToReg_out             = memtoreg_q;
    assign misaligned_out           = misaligned_q;
    assign writebackDestination_out = wbdest_q;
    assign aluResult_out            = alu_q;
    assign memData_out              = memdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_stage: directed-vector self-checking bench for mem_stage.   Rev 1.0
// ============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_RegWrite = 0, in_MemWrite = 0, in_MemRead = 0;
    logic        in_MemToReg = 0, in_Branch = 0, in_zero = 0;
    logic [1:0]  in_load_mode = 0;
    logic [4:0]  in_writebackDestination = 0;
    logic [31:0] in_aluResult = 0, in_rt = 0, in_pc = 0;
    logic        pc_src_out, RegWrite_out, MemToReg_out, misaligned_out;
    logic [31:0] branch_target_out, aluResult_out, memData_out;
    logic [4:0]  writebackDestination_out;

    int n_vec = 0;
    int n_err = 0;

    mem_stage #(.MEM_DEPTH(1024), .ADDR_BITS(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_RegWrite(in_RegWrite), .in_MemWrite(in_MemWrite),
        .in_MemRead(in_MemRead), .in_MemToReg(in_MemToReg),
        .in_Branch(in_Branch), .in_load_mode(in_load_mode),
        .in_zero(in_zero), .in_writebackDestination(in_writebackDestination),
        .in_aluResult(in_aluResult), .in_rt(in_rt), .in_pc(in_pc),
        .pc_src_out(pc_src_out), .branch_target_out(branch_target_out),
        .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
        .writebackDestination_out(writebackDestination_out),
        .aluResult_out(aluResult_out), .memData_out(memData_out),
        .misaligned_out(misaligned_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input logic rd, input logic wr, input logic [1:0] mode,
                       input logic [31:0] addr, input logic [31:0] rt);
        in_MemRead   = rd;
        in_MemWrite  = wr;
        in_load_mode = mode;
        in_aluResult = addr;
        in_rt        = rt;
        tick();
    endtask

    initial begin
        // Reset held: outputs zero
        tick();
        chk("rst_alu",  aluResult_out, 32'd0);
        rst_n = 1'b1;

        // Pass-through fields and async reset between edges
        in_RegWrite = 1; in_MemToReg = 1; in_writebackDestination = 5'd9;
        acc(0, 0, 2'd0, 32'h0000_1234, 32'd0);
        chk("pass_alu",  aluResult_out, 32'h0000_1234);
        chk("pass_dst",  {27'd0, writebackDestination_out}, 32'd9);
        chk("pass_m2r",  {31'd0, MemToReg_out}, 32'd1);
        chk("pass_rw",   {31'd0, RegWrite_out}, 32'd1);
        chk("pass_mdat", memData_out, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_alu", aluResult_out, 32'd0);
        chk("arst_dst", {27'd0, writebackDestination_out}, 32'd0);
        chk("arst_flags", {29'd0, RegWrite_out, MemToReg_out, misaligned_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_RegWrite = 0; in_MemToReg = 0; in_writebackDestination = 0;

        // Word store then load
        acc(0, 1, 2'd0, 32'd32, 32'hDEAD_BEEF);
        chk("st_w_mis", {31'd0, misaligned_out}, 32'd0);
        acc(1, 0, 2'd0, 32'd32, 32'd0);
        chk("ld_w", memData_out, 32'hDEAD_BEEF);

        // Sub-word loads on 0x8899AABB at 8
        acc(0, 1, 2'd0, 32'd8, 32'h8899_AABB);
        acc(1, 0, 2'd2, 32'd9, 32'd0);
        chk("ld_b_s9", memData_out, 32'hFFFF_FFAA);
        acc(1, 0, 2'd3, 32'd9, 32'd0);
        chk("ld_b_u9", memData_out, 32'h0000_00AA);
        acc(1, 0, 2'd1, 32'd10, 32'd0);
        chk("ld_h_s10", memData_out, 32'hFFFF_8899);
        acc(1, 0, 2'd1, 32'd8, 32'd0);
        chk("ld_h_s8", memData_out, 32'hFFFF_AABB);
        acc(1, 0, 2'd3, 32'd11, 32'd0);
        chk("ld_b_u11", memData_out, 32'h0000_0088);

        // Byte store lane isolation
        acc(0, 1, 2'd2, 32'd11, 32'h0000_0011);
        acc(1, 0, 2'd0, 32'd8, 32'd0);
        chk("st_b_lane", memData_out, 32'h1199_AABB);

        // Halfword store into upper lanes
        acc(0, 1, 2'd0, 32'd44, 32'd0);
        acc(0, 1, 2'd1, 32'd46, 32'h1234_BEEF);
        acc(1, 0, 2'd0, 32'd44, 32'd0);
        chk("st_h_hi", memData_out, 32'hBEEF_0000);

        // Misaligned word store suppressed, RegWrite killed
        in_RegWrite = 1;
        acc(0, 1, 2'd0, 32'd34, 32'h0BAD_0BAD);
        chk("mis_st_flag", {31'd0, misaligned_out}, 32'd1);
        chk("mis_st_rw",   {31'd0, RegWrite_out}, 32'd0);
        acc(1, 0, 2'd0, 32'd32, 32'd0);
        chk("mis_st_mem",  memData_out, 32'hDEAD_BEEF);
        chk("al_rw",       {31'd0, RegWrite_out}, 32'd1);
        in_RegWrite = 0;
        acc(1, 0, 2'd1, 32'd33, 32'd0);
        chk("mis_ld_h", {31'd0, misaligned_out}, 32'd1);

        // Read-before-write on the same edge
        acc(0, 1, 2'd0, 32'd28, 32'd7);
        acc(1, 1, 2'd0, 32'd28, 32'd8);
        chk("rbw_old", memData_out, 32'd7);
        acc(1, 0, 2'd0, 32'd28, 32'd0);
        chk("rbw_new", memData_out, 32'd8);

        // Address wraps modulo 4096 bytes
        acc(0, 1, 2'd0, 32'h0000_100C, 32'hCAFE_F00D);
        acc(1, 0, 2'd0, 32'd12, 32'd0);
        chk("wrap", memData_out, 32'hCAFE_F00D);

        // Store on a reset edge is dropped
        acc(0, 1, 2'd0, 32'd40, 32'h0000_0011);
        in_MemWrite = 1; in_aluResult = 32'd40; in_rt = 32'h0000_0055;
        rst_n = 1'b0;
        tick();
        chk("rst_st_out", memData_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        acc(1, 0, 2'd0, 32'd40, 32'd0);
        chk("rst_st_mem", memData_out, 32'h0000_0011);

        // Combinational branch resolution
        in_MemRead = 0;
        in_Branch = 1; in_zero = 1; in_pc = 32'h0000_0400;
        #1;
        chk("br_taken", {31'd0, pc_src_out}, 32'd1);
        chk("br_tgt",   branch_target_out, 32'h0000_0400);
        in_zero = 0;
        #1;
        chk("br_nz", {31'd0, pc_src_out}, 32'd0);
        in_Branch = 0; in_zero = 1;
        #1;
        chk("br_nb", {31'd0, pc_src_out}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
